spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  Single-byte, full-duplex SPI master engine for all four SPI modes.
//  A host loads one byte with a valid pulse; the block generates 8 SCLK cycles,
//  shifts the byte out MSB-first on MOSI and shifts a byte in from MISO.
//  Chip select is not generated here; the surrounding logic owns CS.
//  Back-to-back bytes under one CS are supported via the ready/valid handshake.
// PARAMETERS
//  SPI_MODE           0  0:CPOL0/CPHA0, 1:CPOL0/CPHA1, 2:CPOL1/CPHA0, 3:CPOL1/CPHA1
//  CLKS_PER_HALF_BIT  2  i_Clk cycles per SCLK half-period; legal values >= 2
// PORTS
//  i_Clk       in   1  system clock; all logic on rising edge
//  i_Rst_L     in   1  asynchronous, active-low reset
//  i_TX_Byte   in   8  byte to transmit; sampled when i_TX_DV=1 and o_TX_Ready=1
//  i_TX_DV     in   1  one-cycle load strobe
//  o_TX_Ready  out  1  1 = idle, ready to accept a byte
//  o_RX_DV     out  1  one-cycle pulse: o_RX_Byte holds a newly received byte
//  o_RX_Byte   out  8  last received byte; holds until next o_RX_DV
//  o_SPI_Clk   out  1  SCLK
//  i_SPI_MISO  in   1  serial data from slave
//  o_SPI_MOSI  out  1  serial data to slave
// BEHAVIOUR
//  - CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]. Idle SCLK level = CPOL.
//  - Reset (async): o_SPI_Clk=CPOL, o_SPI_MOSI=0, o_TX_Ready=0, o_RX_DV=0,
//    o_RX_Byte=0, edge counter=0, bit indices=7. o_TX_Ready rises 1 clk after release.
//  - Load: i_TX_DV while o_TX_Ready=1 latches i_TX_Byte, drops o_TX_Ready next
//    clk, sets edge counter to 16. i_TX_DV while o_TX_Ready=0 is ignored.
//  - Edge generator: half-period counter runs 0..2*CLKS_PER_HALF_BIT-1; toggle
//    SCLK at count CLKS_PER_HALF_BIT-1 (leading edge) and 2*CLKS_PER_HALF_BIT-1
//    (trailing edge); each toggle decrements the edge counter. 16 edges total;
//    byte time = 16*CLKS_PER_HALF_BIT clks. SCLK ends at CPOL level.
//  - MOSI, CPHA=0: bit7 driven the clk after load (before first edge); bits 6..0
//    change on trailing edges. CPHA=1: bits 7..0 change on leading edges.
//  - MISO, CPHA=0: sampled on leading edges; CPHA=1: sampled on trailing edges.
//    Shift into o_RX_Byte index 7 down to 0 (MSB first).
//  - After the 8th sample: o_RX_DV=1 for exactly one clk; o_RX_Byte valid then.
//  - When edge counter reaches 0 and no edge pending, o_TX_Ready returns to 1;
//    MOSI holds last bit. Next byte may load in the same cycle ready is seen high.
//  - Reset mid-transfer aborts immediately; no o_RX_DV is emitted for that byte.
//  - No gaps are inserted between bytes beyond the handshake latency (1-2 clks).
// TESTING
//  - Reset: hold i_Rst_L=0 10 clks -> o_SPI_Clk=CPOL, o_TX_Ready=0, o_RX_DV=0;
//    release -> o_TX_Ready=1 within 1 clk.
//  - Loopback MISO=MOSI, mode 0, CLKS_PER_HALF_BIT=4: send 0xC1 -> 8 SCLK
//    periods of 8 clks, MOSI bits 1,1,0,0,0,0,0,1, o_RX_DV pulse, o_RX_Byte=0xC1.
//  - Slave model preloaded 0x54, master sends 0xBE then 0xEF (separate CS) ->
//    slave sees 0xBE, 0xEF; master receives 0x54 then slave's next byte (0x33).
//  - Two bytes under one CS: 0xAA then 0xBB loaded on o_TX_Ready -> exactly 16
//    SCLK pulses, two o_RX_DV pulses, slave receives 0xAA, 0xBB.
//  - Modes 1,2,3 loopback with 0xA5 -> idle SCLK = CPOL, MOSI changes on correct
//    edge, o_RX_Byte=0xA5; i_TX_DV pulsed while busy is ignored.
//  - Assert i_Rst_L=0 after 3 SCLK edges -> outputs return to reset values
//    asynchronously, no o_RX_DV; a later 0x3C transfer completes correctly.

Source files
------------

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  spi_master : single-byte full-duplex SPI master, all four SPI modes
//  Rev 1.0
// ============================================================================
module spi_master #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_SPI_Clk,
  input  logic       i_SPI_MISO,
  output logic       o_SPI_MOSI
);

  localparam logic c_CPOL   = 1'((SPI_MODE >> 1) & 1);
  localparam logic c_CPHA   = 1'(SPI_MODE & 1);
  localparam int   c_HALF_W = $clog2(2 * CLKS_PER_HALF_BIT);
  localparam logic [c_HALF_W-1:0] c_LEAD  = c_HALF_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic [c_HALF_W-1:0] c_TRAIL = c_HALF_W'(2 * CLKS_PER_HALF_BIT - 1);
  localparam logic [c_HALF_W-1:0] c_ONE   = c_HALF_W'(1);

  logic                r_tx_ready;
  logic [4:0]          r_edge_cnt;
  logic [c_HALF_W-1:0] r_half_cnt;
  logic                r_spi_clk;
  logic                r_lead;
  logic                r_trail;
  logic [7:0]          r_tx_byte;
  logic [2:0]          r_tx_idx;
  logic                r_mosi;
  logic [2:0]          r_rx_idx;
  logic [6:0]          r_rx_shift;
  logic [7:0]          r_rx_byte;
  logic                r_rx_dv;
  logic                w_load;
  logic                w_shift_out;
  logic                w_sample_in;

  assign w_load = i_TX_DV & r_tx_ready;
  // The final CPHA=0 trailing edge arrives with the edge counter already at 0;
  // it carries no new bit, so MOSI keeps bit 0.
  assign w_shift_out = c_CPHA ? r_lead : (r_trail && (r_edge_cnt != 5'd0));
  assign w_sample_in = c_CPHA ? r_trail : r_lead;

  // SCLK edge generator; r_lead/r_trail are one-clk strobes per SCLK toggle
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_tx_ready <= 1'b0;
      r_edge_cnt <= 5'd0;
      r_half_cnt <= '0;
      r_spi_clk  <= c_CPOL;
      r_lead     <= 1'b0;
      r_trail    <= 1'b0;
    end else begin
      r_lead  <= 1'b0;
      r_trail <= 1'b0;
      if (w_load) begin
        r_tx_ready <= 1'b0;
        r_edge_cnt <= 5'd16;
        r_half_cnt <= '0;
      end else if (r_edge_cnt != 5'd0) begin
        r_tx_ready <= 1'b0;
        if (r_half_cnt == c_TRAIL) begin
          r_half_cnt <= '0;
          r_edge_cnt <= r_edge_cnt - 5'd1;
          r_trail    <= 1'b1;
          r_spi_clk  <= ~r_spi_clk;
        end else if (r_half_cnt == c_LEAD) begin
          r_half_cnt <= r_half_cnt + c_ONE;
          r_edge_cnt <= r_edge_cnt - 5'd1;
          r_lead     <= 1'b1;
          r_spi_clk  <= ~r_spi_clk;
        end else begin
          r_half_cnt <= r_half_cnt + c_ONE;
        end
      end else begin
        r_tx_ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_tx_byte <= 8'h00;
      r_tx_idx  <= 3'd7;
      r_mosi    <= 1'b0;
    end else if (w_load) begin
      r_tx_byte <= i_TX_Byte;
      if (!c_CPHA) begin
        r_mosi   <= i_TX_Byte[7];
        r_tx_idx <= 3'd6;
      end else begin
        r_tx_idx <= 3'd7;
      end
    end else if (w_shift_out) begin
      r_mosi   <= r_tx_byte[r_tx_idx];
      r_tx_idx <= r_tx_idx - 3'd1;
    end
  end

  // Received bits collect in a shadow register so o_RX_Byte only moves with o_RX_DV
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rx_idx   <= 3'd7;
      r_rx_shift <= 7'd0;
      r_rx_byte  <= 8'h00;
      r_rx_dv    <= 1'b0;
    end else begin
      r_rx_dv <= 1'b0;
      if (w_load) begin
        r_rx_idx <= 3'd7;
      end else if (w_sample_in) begin
        r_rx_shift <= {r_rx_shift[5:0], i_SPI_MISO};
        r_rx_idx   <= r_rx_idx - 3'd1;
        if (r_rx_idx == 3'd0) begin
          r_rx_byte <= {r_rx_shift, i_SPI_MISO};
          r_rx_dv   <= 1'b1;
        end
      end
    end
  end

  assign o_TX_Ready = r_tx_ready;
  assign o_RX_DV    = r_rx_dv;
  assign o_RX_Byte  = r_rx_byte;
  assign o_SPI_Clk  = r_spi_clk;
  assign o_SPI_MOSI = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  tb_spi_master : one DUT per SPI mode, behavioural SPI slave and loopback
//  Rev 1.0
// ============================================================================
module tb_spi_master;

  localparam int c_CPH [4] = '{4, 3, 4, 2};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic [3:0] tx_dv   = 4'h0;
  logic [3:0] ready, rx_dv, sclk, mosi, miso;
  logic [7:0] rx_byte [4];
  int         sel  = 0;
  bit         loop = 1'b1;
  bit         cs   = 1'b0;

  // slave model state
  logic [7:0] s_tx_mem [8];
  int         s_tx_n  = 0;
  int         s_epoch = 0;
  logic [7:0] s_rx_mem [64];
  int         s_rx_n  = 0;
  logic       s_miso  = 1'b0;
  logic [7:0] s_cur   = 8'h00;
  logic [7:0] s_rx    = 8'h00;
  int         s_cnt = 0, s_ptr = 0, prev_epoch = 0, prev_sel = 0;
  logic       prev_sclk = 1'b0, prev_mosi = 1'b0, prev_cs = 1'b0, last_smp = 1'b0;
  int         edges = 0, rxdv_cnt = 0, mosi_viol = 0;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      assign miso[g] = loop ? mosi[g] : s_miso;
      spi_master #(.SPI_MODE(g), .CLKS_PER_HALF_BIT(c_CPH[g])) u_dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_n),
        .i_TX_Byte  (tx_byte),
        .i_TX_DV    (tx_dv[g]),
        .o_TX_Ready (ready[g]),
        .o_RX_DV    (rx_dv[g]),
        .o_RX_Byte  (rx_byte[g]),
        .o_SPI_Clk  (sclk[g]),
        .i_SPI_MISO (miso[g]),
        .o_SPI_MOSI (mosi[g])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] next_slave_byte(input int p);
    return (p < s_tx_n) ? s_tx_mem[p] : 8'h00;
  endfunction

  // Behavioural slave on the selected DUT: samples MOSI on the mode's sample
  // edge, presents its next bit on the opposite edge.
  always @(negedge clk) begin
    logic cpol, cpha, lead, smp;
    cpol = sel[1];
    cpha = sel[0];
    if (rx_dv[sel]) rxdv_cnt++;
    if (sel != prev_sel || !rst_n) begin
      prev_sel  = sel;
      prev_sclk = sclk[sel];
      prev_mosi = mosi[sel];
      s_cnt     = 0;
      last_smp  = 1'b0;
    end else begin
      if (s_epoch != prev_epoch || (cs && !prev_cs)) begin
        if (s_epoch != prev_epoch) begin
          prev_epoch = s_epoch;
          s_ptr = 0;
          s_cur = next_slave_byte(s_ptr);
          s_ptr++;
        end
        s_cnt  = 0;
        s_miso = s_cur[7];
      end
      if (mosi[sel] != prev_mosi && last_smp) mosi_viol++;
      if (sclk[sel] != prev_sclk) begin
        lead = (prev_sclk == cpol);
        smp  = (lead != cpha);
        edges++;
        last_smp = smp;
        if (cs) begin
          if (smp) begin
            s_rx = {s_rx[6:0], mosi[sel]};
            s_cnt++;
            if (s_cnt == 8) begin
              s_rx_mem[s_rx_n % 64] = s_rx;
              s_rx_n++;
              s_cnt = 0;
              s_cur = next_slave_byte(s_ptr);
              s_ptr++;
            end
          end else begin
            s_miso = s_cur[7 - s_cnt];
          end
        end
      end
      prev_sclk = sclk[sel];
      prev_mosi = mosi[sel];
      prev_cs   = cs;
    end
  end

  task automatic xfer(input logic [7:0] b, input logic [7:0] exp_rx, input bit poke);
    int t, low, e0, d0, c;
    bit got;
    logic [7:0] rxv;
    c = c_CPH[sel];
    t = 0;
    while (ready[sel] !== 1'b1 && t < 100) begin tick(); t++; end
    chk($sformatf("m%0d ready_before_load", sel), 32'(ready[sel]), 1);
    e0 = edges;
    d0 = rxdv_cnt;
    tx_byte = b;
    tx_dv[sel] = 1'b1;
    tick();
    tx_dv = 4'h0;
    low = 0; got = 1'b0; rxv = 8'h00; t = 0;
    while (t < 400) begin
      if (rx_dv[sel]) begin got = 1'b1; rxv = rx_byte[sel]; end
      if (ready[sel]) break;
      low++;
      if (poke && t == 5) begin tx_byte = ~b; tx_dv[sel] = 1'b1; end
      else tx_dv = 4'h0;
      tick();
      t++;
    end
    tx_dv = 4'h0;
    chk($sformatf("m%0d rx_dv_seen", sel), 32'(got), 1);
    chk($sformatf("m%0d rx_byte", sel), 32'(rxv), 32'(exp_rx));
    chk($sformatf("m%0d rx_byte_hold", sel), 32'(rx_byte[sel]), 32'(exp_rx));
    chk($sformatf("m%0d rx_dv_pulses", sel), 32'(rxdv_cnt - d0), 1);
    chk($sformatf("m%0d sclk_edges", sel), 32'(edges - e0), 16);
    chk($sformatf("m%0d busy_len=%0d", sel, low), 32'(low >= 16*c+1 && low <= 16*c+2), 1);
    chk($sformatf("m%0d sclk_idle", sel), 32'(sclk[sel]), 32'(sel[1]));
  endtask

  task automatic load_slave(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int n);
    s_tx_mem[0] = b0; s_tx_mem[1] = b1; s_tx_mem[2] = b2; s_tx_mem[3] = b3;
    s_tx_n = n;
    s_epoch++;
    tick();
  endtask

  task automatic chk_slave(input int idx, input logic [7:0] exp);
    chk($sformatf("m%0d slave_rx[%0d]", sel, idx), 32'(s_rx_mem[idx % 64]), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t, e0, d0;
    logic [7:0] mb [4];
    logic [7:0] b;

    // reset state
    rst_n = 1'b0;
    repeat (10) tick();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst sclk%0d", g), 32'(sclk[g]), 32'((g >> 1) & 1));
      chk($sformatf("rst ready%0d", g), 32'(ready[g]), 0);
      chk($sformatf("rst rx_dv%0d", g), 32'(rx_dv[g]), 0);
      chk($sformatf("rst mosi%0d", g), 32'(mosi[g]), 0);
      chk($sformatf("rst rx_byte%0d", g), 32'(rx_byte[g]), 0);
    end
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", 32'(ready), 32'hF);

    // mode 0 loopback 0xC1, MOSI bit pattern captured by the slave
    sel = 0; loop = 1'b1; cs = 1'b1;
    load_slave(8'h00, 8'h00, 8'h00, 8'h00, 0);
    base = s_rx_n;
    xfer(8'hC1, 8'hC1, 1'b0);
    chk_slave(base, 8'hC1);

    // slave preloaded 0x54/0x33, two bytes with CS toggled between
    loop = 1'b0;
    load_slave(8'h54, 8'h33, 8'h00, 8'h00, 2);
    base = s_rx_n;
    xfer(8'hBE, 8'h54, 1'b0);
    cs = 1'b0; tick(); cs = 1'b1; tick();
    xfer(8'hEF, 8'h33, 1'b0);
    chk_slave(base, 8'hBE);
    chk_slave(base + 1, 8'hEF);

    // two bytes back-to-back under one CS
    load_slave(8'h11, 8'h22, 8'h00, 8'h00, 2);
    base = s_rx_n;
    e0 = edges;
    xfer(8'hAA, 8'h11, 1'b0);
    xfer(8'hBB, 8'h22, 1'b0);
    chk("b2b total_edges", 32'(edges - e0), 32);
    chk_slave(base, 8'hAA);
    chk_slave(base + 1, 8'hBB);

    // modes 1..3 loopback 0xA5 with a load strobe while busy
    loop = 1'b1;
    for (int m = 1; m < 4; m++) begin
      sel = m; tick();
      xfer(8'hA5, 8'hA5, 1'b1);
    end

    // reset part way through a transfer
    sel = 0; loop = 1'b1; tick();
    e0 = edges; d0 = rxdv_cnt;
    tx_byte = 8'h96; tx_dv[0] = 1'b1; tick(); tx_dv = 4'h0;
    t = 0;
    while (edges - e0 < 3 && t < 200) begin tick(); t++; end
    chk("midrst edges_reached", 32'(edges - e0 >= 3), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst sclk", 32'(sclk[0]), 0);
    chk("midrst ready", 32'(ready[0]), 0);
    chk("midrst rx_dv", 32'(rx_dv[0]), 0);
    chk("midrst mosi", 32'(mosi[0]), 0);
    repeat (10) tick();
    chk("midrst no_rx_dv", 32'(rxdv_cnt - d0), 0);
    rst_n = 1'b1;
    tick();
    chk("midrst ready_after_release", 32'(ready[0]), 1);
    xfer(8'h3C, 8'h3C, 1'b0);

    // randomized traffic on every mode: loopback, then against the slave
    for (int m = 0; m < 4; m++) begin
      sel = m; loop = 1'b1; tick();
      for (int k = 0; k < 3; k++) begin
        b = 8'($urandom_range(0, 255));
        xfer(b, b, 1'($urandom_range(0, 1)));
      end
      loop = 1'b0;
      load_slave(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4);
      base = s_rx_n;
      for (int k = 0; k < 4; k++) begin
        mb[k] = 8'($urandom_range(0, 255));
        xfer(mb[k], s_tx_mem[k], 1'b0);
      end
      for (int k = 0; k < 4; k++) chk_slave(base + k, mb[k]);
    end

    chk("mosi_change_on_sample_edge", 32'(mosi_viol), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
